bus_scheduler: RTL and testbench
================================

# bus_scheduler

Time-division scheduler for the shared PET SRAM/ROM bus. Divides each 1 µs frame of sixteen `clk16_i` cycles into fixed slots and issues the one-hot bus enables and phase clocks: `cpu_en`, `vram0_en`, `vrom0_en`, `vram1_en`, `vrom1_en`, `setup_clk`, `strobe_clk` and `cclk_en`. These drive the CPU interface, the video fetch path and the CRTC. It also grants an optional auxiliary requester (SPI/debug loader) a window through a request/grant/ack handshake.

## Interface
- No parameters; frame length (16) and slot map are package constants.
- `clk16_i` in 1: 16 MHz system clock; all state on its rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `col_80_mode_i` in 1: 1 enables odd-column fetch slots; sampled at frame boundary.
- `aux_req_i` in 1: auxiliary bus request, level, held until ack.
- `aux_grant_o` out 1: auxiliary owns bus (counts 8–11).
- `aux_ack_o` out 1: one-cycle pulse, aux transaction complete.
- `cpu_en_o` out 1: CPU slot active.
- `vram0_en_o` / `vrom0_en_o` / `vram1_en_o` / `vrom1_en_o` out 1 each: video fetch slots.
- `setup_clk_o` out 1: address-setup phase of current slot.
- `strobe_clk_o` out 1: strobe phase; consumers latch data on its falling edge.
- `cclk_en_o` out 1: 1 MHz character-clock enable for the CRTC.
- `count_o` out 4: current frame position, for debug and bench alignment.

## Operation
- 4-bit counter `count` increments every clock, wrapping 15→0. Slot = `count[3:1]`, phase = `count[0]`.
- Slot map:
  - counts 0–1: vram0
  - 2–3: vrom0
  - 4–5: vram1
  - 6–7: vrom1
  - 8–11: aux window
  - 12–15: cpu
- `setup_clk_o` = 1 at even counts, `strobe_clk_o` = 1 at odd counts; both 0 during reset.
- `vram1_en_o` / `vrom1_en_o` assert only if the registered 80-column flag is 1. Otherwise counts 4–7 are idle, but `setup_clk_o`/`strobe_clk_o` still toggle.
- `cclk_en_o` = 1 at count 15 only.
- Aux FSM states:
  - IDLE → PENDING when `aux_req_i` = 1 at count 7. A request later than count 7 waits for the next frame.
  - PENDING → GRANT at count 8.
  - GRANT holds counts 8–11 with `aux_ack_o` = 1 at count 11.
  - GRANT → IDLE at count 12.
- If `aux_req_i` is still high at the next count 7, the aux is granted again (back-to-back frames allowed).
- Dropping `aux_req_i` mid-grant does not abort: the grant runs to count 11 and ack still pulses.
- Bus enables are mutually exclusive in every cycle; `aux_grant_o` never overlaps `cpu_en_o`.

## Timing
- All outputs are registered. In the cycle where `count_o` = n, every output equals decode(n), so there is zero cycles of skew between outputs.
- Reset asserted: all outputs 0 immediately (asynchronous). Internal count is held at 15, aux FSM in IDLE, 80-column flag = 1.
- First rising edge after reset release: `count_o` = 0 and `vram0_en_o` = 1. Thus the first frame always starts at slot 0.
- `col_80_mode_i` is sampled at count 15 and takes effect from count 0 of the next frame. A mid-frame change has no effect until then.
- Reset asserted mid-grant kills `aux_grant_o` and `aux_ack_o` without an ack; the requester must re-request.
- Aux grant latency: request seen at count 7 gives grant at count 8 (1 cycle). Worst case is 16 cycles, for a request arriving at count 8.

## Configuration
- `BUS_SCHED_AUX_EN` defined: the aux FSM and handshake behave as above.
- Not defined:
  - counts 8–11 are idle, with no enable asserted;
  - `aux_grant_o` and `aux_ack_o` are tied to 0;
  - `aux_req_i` is ignored;
  - no aux FSM flops are present.
- CPU, video and clock timing are identical in both builds.

## Structure
- Package `bus_sched_pkg`:
  - `FRAME_LEN` = 16;
  - slot start/end count constants;
  - `slot_t` enum (`SLOT_VRAM0`, `SLOT_VROM0`, `SLOT_VRAM1`, `SLOT_VROM1`, `SLOT_AUX`, `SLOT_CPU`);
  - `aux_state_t` enum (`AUX_IDLE`, `AUX_PENDING`, `AUX_GRANT`).
- One sub-module, `bus_slot_decode`: combinational next-count to `slot_t` plus phase decode, feeding the output registers.
- The top level holds the counter, the 80-column flag, the aux FSM and the output registers.

## Test plan
- Reset release, `col_80_mode_i` = 1, `aux_req_i` = 0 → over 32 cycles, enables follow the slot map exactly; `cclk_en_o` pulses at counts 15 and 31; setup/strobe alternate; enables are always one-hot or zero.
- `col_80_mode_i` = 0 → `vram1_en_o`/`vrom1_en_o` stay 0 for the whole frame; other slots unchanged.
- `col_80_mode_i` toggled at count 5 → current frame unchanged; new mode applies from the next count 0.
- `aux_req_i` raised at count 3 and held → `aux_grant_o` = 1 at counts 8–11, `aux_ack_o` at count 11; regranted next frame while held.
- `aux_req_i` raised at count 9, dropped at count 10 of the following frame → grant in the following frame only, full 4 cycles, single ack.
- `reset_i` pulsed at count 9 during a grant → all outputs 0 asynchronously, no ack; after release, `count_o` = 0 and `vram0_en_o` = 1 on the first edge.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared constants and types for the PET bus time-division scheduler.
// One frame is sixteen clk16 cycles; slot boundaries are fixed here.
package bus_sched_pkg;

    localparam int FRAME_LEN = 16;

    localparam logic [3:0] VRAM0_START = 4'd0;
    localparam logic [3:0] VRAM0_END   = 4'd1;
    localparam logic [3:0] VROM0_START = 4'd2;
    localparam logic [3:0] VROM0_END   = 4'd3;
    localparam logic [3:0] VRAM1_START = 4'd4;
    localparam logic [3:0] VRAM1_END   = 4'd5;
    localparam logic [3:0] VROM1_START = 4'd6;
    localparam logic [3:0] VROM1_END   = 4'd7;
    localparam logic [3:0] AUX_START   = 4'd8;
    localparam logic [3:0] AUX_END     = 4'd11;
    localparam logic [3:0] CPU_START   = 4'd12;
    localparam logic [3:0] CPU_END     = 4'd15;

    // Aux request sample point and the count that closes a frame.
    localparam logic [3:0] AUX_REQ_COUNT = 4'd7;
    localparam logic [3:0] FRAME_LAST    = 4'd15;

    typedef enum logic [2:0] {
        SLOT_VRAM0,
        SLOT_VROM0,
        SLOT_VRAM1,
        SLOT_VROM1,
        SLOT_AUX,
        SLOT_CPU
    } slot_t;

    typedef enum logic [1:0] {
        AUX_IDLE,
        AUX_PENDING,
        AUX_GRANT
    } aux_state_t;

endpackage

// File: rtl/bus_slot_decode.sv
// Combinational decode of a frame count into its owning slot and phase clocks.
// Zero latency; fed with the next count so the top can register the result.
module bus_slot_decode
    import bus_sched_pkg::*;
(
    input  logic [3:0] count_i,
    output slot_t      slot_o,
    output logic       setup_o,
    output logic       strobe_o,
    output logic       cclk_o
);

    always_comb begin
        slot_o = SLOT_CPU;
        if (count_i <= VRAM0_END) begin
            slot_o = SLOT_VRAM0;
        end else if (count_i <= VROM0_END) begin
            slot_o = SLOT_VROM0;
        end else if (count_i <= VRAM1_END) begin
            slot_o = SLOT_VRAM1;
        end else if (count_i <= VROM1_END) begin
            slot_o = SLOT_VROM1;
        end else if (count_i <= AUX_END) begin
            slot_o = SLOT_AUX;
        end
    end

    assign setup_o  = ~count_i[0];
    assign strobe_o = count_i[0];
    assign cclk_o   = (count_i == FRAME_LAST);

endmodule

// File: rtl/bus_scheduler.sv
// Frame scheduler for the shared PET SRAM/ROM bus; every output is registered from decode(next count).
// BUS_SCHED_AUX_EN adds the aux request/grant/ack window at counts 8-11; without it those counts idle.
module bus_scheduler
    import bus_sched_pkg::*;
(
    input  logic       clk16_i,
    input  logic       reset_i,
    input  logic       col_80_mode_i,
    input  logic       aux_req_i,
    output logic       aux_grant_o,
    output logic       aux_ack_o,
    output logic       cpu_en_o,
    output logic       vram0_en_o,
    output logic       vrom0_en_o,
    output logic       vram1_en_o,
    output logic       vrom1_en_o,
    output logic       setup_clk_o,
    output logic       strobe_clk_o,
    output logic       cclk_en_o,
    output logic [3:0] count_o
);

    logic [3:0] count_q, count_d;
    logic [3:0] count_out_q;
    logic       col80_q;
    slot_t      slot_d;
    logic       setup_d, strobe_d, cclk_d;
    logic       cpu_q, vram0_q, vrom0_q, vram1_q, vrom1_q;
    logic       setup_q, strobe_q, cclk_q;

    assign count_d = count_q + 4'd1;

    bus_slot_decode u_decode (
        .count_i  (count_d),
        .slot_o   (slot_d),
        .setup_o  (setup_d),
        .strobe_o (strobe_d),
        .cclk_o   (cclk_d)
    );

    // Internal count parks at 15 in reset so the first edge lands on slot 0.
    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            count_q     <= FRAME_LAST;
            count_out_q <= 4'd0;
            col80_q     <= 1'b1;
            cpu_q       <= 1'b0;
            vram0_q     <= 1'b0;
            vrom0_q     <= 1'b0;
            vram1_q     <= 1'b0;
            vrom1_q     <= 1'b0;
            setup_q     <= 1'b0;
            strobe_q    <= 1'b0;
            cclk_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            count_out_q <= count_d;
            if (count_q == FRAME_LAST) begin
                col80_q <= col_80_mode_i;
            end
            cpu_q    <= (slot_d == SLOT_CPU);
            vram0_q  <= (slot_d == SLOT_VRAM0);
            vrom0_q  <= (slot_d == SLOT_VROM0);
            vram1_q  <= (slot_d == SLOT_VRAM1) && col80_q;
            vrom1_q  <= (slot_d == SLOT_VROM1) && col80_q;
            setup_q  <= setup_d;
            strobe_q <= strobe_d;
            cclk_q   <= cclk_d;
        end
    end

`ifdef BUS_SCHED_AUX_EN
    aux_state_t aux_state_q;
    logic       aux_grant_q, aux_ack_q;

    // Grant is raised on the edge that leaves count 7 so it is visible from count 8.
    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            aux_state_q <= AUX_IDLE;
            aux_grant_q <= 1'b0;
            aux_ack_q   <= 1'b0;
        end else begin
            aux_ack_q <= 1'b0;
            case (aux_state_q)
                AUX_IDLE: begin
                    if ((count_q == AUX_REQ_COUNT) && aux_req_i) begin
                        aux_state_q <= AUX_PENDING;
                        aux_grant_q <= 1'b1;
                    end
                end
                AUX_PENDING: begin
                    aux_state_q <= AUX_GRANT;
                end
                AUX_GRANT: begin
                    if (count_d == AUX_END) begin
                        aux_ack_q <= 1'b1;
                    end
                    if (count_q == AUX_END) begin
                        aux_state_q <= AUX_IDLE;
                        aux_grant_q <= 1'b0;
                    end
                end
                default: begin
                    aux_state_q <= AUX_IDLE;
                    aux_grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign aux_grant_o = aux_grant_q;
    assign aux_ack_o   = aux_ack_q;
`else
    logic unused_aux_req;
    assign unused_aux_req = aux_req_i;
    assign aux_grant_o    = 1'b0;
    assign aux_ack_o      = 1'b0;
`endif

    assign cpu_en_o     = cpu_q;
    assign vram0_en_o   = vram0_q;
    assign vrom0_en_o   = vrom0_q;
    assign vram1_en_o   = vram1_q;
    assign vrom1_en_o   = vrom1_q;
    assign setup_clk_o  = setup_q;
    assign strobe_clk_o = strobe_q;
    assign cclk_en_o    = cclk_q;
    assign count_o      = count_out_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Bench for bus_scheduler: slot-map table, hand-written aux/reset sequences and a randomized run.
module tb_bus_scheduler;

    logic       clk16_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       col_80_mode_i = 1'b1;
    logic       aux_req_i = 1'b0;
    logic       aux_grant_o, aux_ack_o, cpu_en_o;
    logic       vram0_en_o, vrom0_en_o, vram1_en_o, vrom1_en_o;
    logic       setup_clk_o, strobe_clk_o, cclk_en_o;
    logic [3:0] count_o;

`ifdef BUS_SCHED_AUX_EN
    localparam bit AUX_EN = 1'b1;
`else
    localparam bit AUX_EN = 1'b0;
`endif

    bus_scheduler dut (
        .clk16_i       (clk16_i),
        .reset_i       (reset_i),
        .col_80_mode_i (col_80_mode_i),
        .aux_req_i     (aux_req_i),
        .aux_grant_o   (aux_grant_o),
        .aux_ack_o     (aux_ack_o),
        .cpu_en_o      (cpu_en_o),
        .vram0_en_o    (vram0_en_o),
        .vrom0_en_o    (vrom0_en_o),
        .vram1_en_o    (vram1_en_o),
        .vrom1_en_o    (vrom1_en_o),
        .setup_clk_o   (setup_clk_o),
        .strobe_clk_o  (strobe_clk_o),
        .cclk_en_o     (cclk_en_o),
        .count_o       (count_o)
    );

    always #31 clk16_i = ~clk16_i;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;

    // Reference model: frame position plus the per-frame decisions taken at counts 15 and 7.
    int m_cnt   = 15;
    bit m_col80 = 1'b1;
    bit m_aux   = 1'b0;

    // Bit order: {cpu, vram0, vrom0, vram1, vrom1, grant, ack, setup, strobe, cclk}
    function automatic logic [9:0] expect_out(int c, bit col80, bit aux);
        logic [9:0] v;
        v    = '0;
        v[9] = (c >= 12);
        v[8] = (c < 2);
        v[7] = (c >= 2) && (c < 4);
        v[6] = col80 && (c >= 4) && (c < 6);
        v[5] = col80 && (c >= 6) && (c < 8);
        v[4] = aux && (c >= 8) && (c < 12);
        v[3] = aux && (c == 11);
        v[2] = (c % 2 == 0);
        v[1] = (c % 2 == 1);
        v[0] = (c == 15);
        return v;
    endfunction

    function automatic logic [9:0] dut_out();
        return {cpu_en_o, vram0_en_o, vrom0_en_o, vram1_en_o, vrom1_en_o,
                aux_grant_o, aux_ack_o, setup_clk_o, strobe_clk_o, cclk_en_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock with the model, then compare every output at the falling edge.
    task automatic step();
        if (m_cnt == 15) m_col80 = col_80_mode_i;
        if (m_cnt == 7)  m_aux   = AUX_EN && aux_req_i;
        m_cnt = (m_cnt + 1) % 16;
        @(posedge clk16_i);
        @(negedge clk16_i);
        check("count", 32'(count_o), 32'(m_cnt));
        check("outputs", 32'(dut_out()), 32'(expect_out(m_cnt, m_col80, m_aux)));
        check("exclusive", 32'($countones({cpu_en_o, vram0_en_o, vrom0_en_o,
              vram1_en_o, vrom1_en_o, aux_grant_o}) <= 1), 32'd1);
        if (aux_ack_o) ack_cnt++;
    endtask

    task automatic wait_count(input logic [3:0] target);
        step();
        for (int k = 0; k < 20 && count_o != target; k++) step();
        check("wait_count", 32'(count_o), 32'(target));
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        #1;
        check("rst_async", 32'({count_o, dut_out()}), 32'd0);
        m_cnt   = 15;
        m_col80 = 1'b1;
        m_aux   = 1'b0;
        @(negedge clk16_i);
        @(negedge clk16_i);
        check("rst_hold", 32'({count_o, dut_out()}), 32'd0);
        reset_i = 1'b0;
    endtask

    typedef struct {
        bit         mode;
        logic [3:0] cnt;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{1'b1, 4'd0,  10'b0100000100};
        tbl[1]  = '{1'b1, 4'd1,  10'b0100000010};
        tbl[2]  = '{1'b1, 4'd2,  10'b0010000100};
        tbl[3]  = '{1'b1, 4'd3,  10'b0010000010};
        tbl[4]  = '{1'b1, 4'd4,  10'b0001000100};
        tbl[5]  = '{1'b1, 4'd5,  10'b0001000010};
        tbl[6]  = '{1'b1, 4'd6,  10'b0000100100};
        tbl[7]  = '{1'b1, 4'd7,  10'b0000100010};
        tbl[8]  = '{1'b1, 4'd8,  10'b0000000100};
        tbl[9]  = '{1'b1, 4'd9,  10'b0000000010};
        tbl[10] = '{1'b1, 4'd10, 10'b0000000100};
        tbl[11] = '{1'b1, 4'd11, 10'b0000000010};
        tbl[12] = '{1'b1, 4'd12, 10'b1000000100};
        tbl[13] = '{1'b1, 4'd13, 10'b1000000010};
        tbl[14] = '{1'b1, 4'd14, 10'b1000000100};
        tbl[15] = '{1'b1, 4'd15, 10'b1000000011};
        tbl[16] = '{1'b0, 4'd4,  10'b0000000100};
        tbl[17] = '{1'b0, 4'd5,  10'b0000000010};
        tbl[18] = '{1'b0, 4'd6,  10'b0000000100};
        tbl[19] = '{1'b0, 4'd7,  10'b0000000010};

        #10;
        apply_reset();

        // Slot map, 80-column then 40-column frame.
        for (int i = 0; i < 20; i++) begin
            col_80_mode_i = tbl[i].mode;
            wait_count(tbl[i].cnt);
            check($sformatf("tbl[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
        end
        repeat (24) step();

        // Mode change at count 5 only takes effect next frame.
        wait_count(4'd5);
        col_80_mode_i = 1'b1;
        wait_count(4'd6);
        check("mid_toggle_hold", 32'(vrom1_en_o), 32'd0);
        wait_count(4'd6);
        check("mid_toggle_apply", 32'(vrom1_en_o), 32'd1);

        // Request held from count 3: two consecutive grants.
        wait_count(4'd3);
        aux_req_i = 1'b1;
        ack_cnt   = 0;
        repeat (32) step();
        check("ack_held", 32'(ack_cnt), AUX_EN ? 32'd2 : 32'd0);
        aux_req_i = 1'b0;
        repeat (16) step();

        // Request at count 9, dropped at count 10 of the next frame.
        wait_count(4'd9);
        aux_req_i = 1'b1;
        ack_cnt   = 0;
        repeat (17) step();
        check("late_at_10", 32'(count_o), 32'd10);
        check("late_grant", 32'(aux_grant_o), 32'(AUX_EN));
        aux_req_i = 1'b0;
        repeat (16) step();
        check("ack_late", 32'(ack_cnt), AUX_EN ? 32'd1 : 32'd0);

        // Reset in the middle of a grant.
        aux_req_i = 1'b1;
        wait_count(4'd7);
        wait_count(4'd9);
        check("grant_before_rst", 32'(aux_grant_o), 32'(AUX_EN));
        aux_req_i = 1'b0;
        ack_cnt   = 0;
        #5;
        apply_reset();
        step();
        check("post_rst_vram0", 32'({count_o, vram0_en_o}), 32'd1);
        repeat (15) step();
        check("ack_after_rst", 32'(ack_cnt), 32'd0);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) col_80_mode_i = ~col_80_mode_i;
            if ($urandom_range(0, 3) == 0) aux_req_i = ~aux_req_i;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
